// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum is exported so the FSM state can be observed on the debug port.
package loader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CSUM = 2'b10
    } err_code_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes, LSB first, into one 32-bit word.
// word_valid/word are combinational on the 4th accepted byte so the caller can register the write.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] sr_q,  sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_in, sr_q[WORD_W-1:8]};
        end
    end

    assign word_valid = byte_en && !clear && (cnt_q == 2'd3);
    assign word       = {byte_in, sr_q[WORD_W-1:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// and releases the core only after the whole image has been written and verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready;
    // byte_ready depends only on state, never on byte_valid.

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              hs;
    logic              pk_clear;
    logic              pk_en;
    logic              pk_word_valid;
    logic [WORD_W-1:0] pk_word;
    logic [15:0]       len_full;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .byte_in    (byte_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    assign byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CSUM);
    assign busy        = byte_ready;
    assign done        = (state_q == DONE);
    assign core_enable = (state_q == DONE);
    assign error       = (state_q == ERR);
    assign err_code    = err_code_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign dbg_state   = state_q;

    assign hs       = byte_valid && byte_ready;
    assign len_full = {byte_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        widx_d     = widx_q;
        csum_d     = csum_q;
        err_code_d = err_code_q;
        pk_clear   = 1'b0;
        pk_en      = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN0;
                    len_d      = '0;
                    widx_d     = '0;
                    csum_d     = '0;
                    err_code_d = ERR_NONE;
                    pk_clear   = 1'b1;
                end
            end
            LEN0: begin
                if (hs) begin
                    len_d[7:0] = byte_data;
                    csum_d     = csum_q ^ byte_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (hs) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ byte_data;
                    if (17'(len_full) > 17'(DEPTH)) begin
                        state_d    = ERR;
                        err_code_d = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    csum_d = csum_q ^ byte_data;
                    pk_en  = 1'b1;
                    if (pk_word_valid) begin
                        widx_d = widx_q + 1'b1;
                        if (17'(widx_q) + 17'd1 == 17'(len_q)) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (hs) begin
                    if (byte_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port is registered: the word lands in memory the cycle after its 4th byte.
    always_comb begin
        we_d    = pk_word_valid;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (pk_word_valid) begin
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = pk_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            widx_q     <= '0;
            csum_q     <= '0;
            err_code_q <= ERR_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            csum_q     <= csum_d;
            err_code_q <= err_code_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are parsed by a reference model
// that predicts memory writes and the final session outcome.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_enable;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [39:0] exp_q[$];
    logic        exp_done;
    logic        exp_error;
    logic [1:0]  exp_code;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_enable (core_enable),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe must match the next predicted (addr, word)
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'd0, imem_addr, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write", {24'd0, imem_addr, imem_wdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // reference model: parse the stream by its format rules
    task automatic model_session(input byte_q_t s);
        int n;
        logic [7:0] x;
        n = int'(s[0]) + (int'(s[1]) << 8);
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_code  = 2'b00;
        if (n > DEPTH) begin
            exp_error = 1'b1;
            exp_code  = 2'b01;
            return;
        end
        for (int w = 0; w < n; w++) begin
            logic [31:0] word;
            word = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
            exp_q.push_back({8'(w), word});
        end
        x = 8'h00;
        for (int i = 0; i < s.size() - 1; i++) x = x ^ s[i];
        if (s[s.size()-1] == x) begin
            exp_done = 1'b1;
        end else begin
            exp_error = 1'b1;
            exp_code  = 2'b10;
        end
    endtask

    function automatic byte_q_t make_stream(input int n, input bit bad_csum);
        byte_q_t s;
        logic [7:0] x;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n > DEPTH) return s;
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
        return s;
    endfunction

    // driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", {63'd0, byte_ready}, 64'd1);
    endtask

    task automatic send_bytes(input byte_q_t s, input int gmin, input int gmax, input bit mid_start);
        for (int i = 0; i < s.size(); i++) begin
            int gaps;
            int t;
            gaps = $urandom_range(gmax, gmin);
            repeat (gaps) begin
                @(negedge clk);
                byte_valid = 1'b0;
            end
            if (mid_start && i == 1) begin
                @(negedge clk);
                byte_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = s[i];
            t = 0;
            while (!byte_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!byte_ready) begin
                check("byte_ready_wait", {63'd0, byte_ready}, 64'd1);
                byte_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_final(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
        check({tag, "_error"}, {63'd0, error}, {63'd0, exp_error});
        check({tag, "_err_code"}, {62'd0, err_code}, {62'd0, exp_code});
        check({tag, "_core_enable"}, {63'd0, core_enable}, {63'd0, exp_done});
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
        exp_q.delete();
    endtask

    task automatic run_session(input string tag, input byte_q_t s, input int gmin, input int gmax,
                               input bit mid_start);
        model_session(s);
        pulse_start();
        send_bytes(s, gmin, gmax, mid_start);
        check_final(tag);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"},
              {55'd0, byte_ready, imem_we, core_enable, busy, done, error, err_code, 1'b0},
              64'd0);
        check({tag, "_state"}, {61'd0, dbg_state}, 64'd0);
    endtask

    initial begin
        byte_q_t s1, s2, s3, s4, s6;
        s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h43};
        s2 = '{8'h00, 8'h00, 8'h00};
        s3 = '{8'h01, 8'h01};
        s4 = s1;
        s4[10] = 8'h44;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_session("two_word", s1, 0, 0, 1'b0);
        run_session("empty", s2, 0, 0, 1'b0);
        run_session("overflow", s3, 0, 0, 1'b0);
        run_session("bad_csum", s4, 0, 0, 1'b0);
        run_session("throttled", s1, 3, 3, 1'b0);
        run_session("start_ignored", s1, 0, 2, 1'b1);

        // reset during DATA after one full word plus two bytes
        s6 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81};
        exp_q.push_back({8'h00, 32'h0050_0093});
        pulse_start();
        send_bytes(s6, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_writes", 64'(exp_q.size()), 64'd0);
        check_idle_outputs("rst_mid");
        run_session("reload", s1, 0, 1, 1'b0);

        run_session("full_depth", make_stream(DEPTH, 1'b0), 0, 1, 1'b0);
        run_session("depth_plus1", make_stream(DEPTH + 1, 1'b0), 0, 1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            int n;
            bit bad;
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, 65535) : $urandom_range(0, 8);
            bad = ($urandom_range(0, 3) == 0);
            run_session("random", make_stream(n, bad), 0, 3, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
